// File: rtl/modem_stream_pkg.sv
// -----------------------------------------------------------------------------
// modem_stream_pkg
// Definitions shared by the modem sample-stream blocks: the default sample width,
// the interpolator state encoding and the midpoint helper. The receive-side
// half-sample phase shifter also uses the midpoint helper.
// -----------------------------------------------------------------------------
package modem_stream_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no output pending
        MID   = 2'd1,   // midpoint presented on output
        ORIG  = 2'd2    // original sample presented on output
    } interp_state_t;

    // Floor of (a+b)/2. The sum is formed one bit wider, so it cannot overflow.
    // Dropping the LSB of the sum is an arithmetic shift right by one.
    function automatic logic signed [DATA_W_DEF-1:0] mid2(
        input logic signed [DATA_W_DEF-1:0] a,
        input logic signed [DATA_W_DEF-1:0] b
    );
        logic signed [DATA_W_DEF:0] sum;
        sum = {a[DATA_W_DEF-1], a} + {b[DATA_W_DEF-1], b};
        return sum[DATA_W_DEF:1];
    endfunction

endpackage

// File: rtl/interp2x_linear.sv
// -----------------------------------------------------------------------------
// interp2x_linear
// 2x linear interpolator for signed sample streams. For each accepted input x[n]
// the block emits the midpoint floor((x[n-1]+x[n])/2) with tuser=1, and then
// x[n] itself with tuser=0. Both ports use full AXI-Stream handshaking.
//
// Ports
//   s_axis_aclk    clock, rising edge
//   rst            synchronous reset, active high
//   s_axis_tdata   input sample (signed)
//   s_axis_tvalid  input valid
//   s_axis_tready  input ready. Combinational from state and m_axis_tready only.
//   m_axis_tdata   output sample (signed, registered)
//   m_axis_tvalid  output valid (registered)
//   m_axis_tready  downstream ready
//   m_axis_tuser   1 = interpolated midpoint, 0 = original sample
// -----------------------------------------------------------------------------
module interp2x_linear
    import modem_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              s_axis_aclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser
);

    interp_state_t     state;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] mid_val;
    logic              in_xfer;
    logic              out_xfer;

    // A new sample is accepted while idle. In ORIG, a new sample is accepted
    // only when the original is leaving in the same cycle. This keeps one output
    // per cycle when inputs arrive back to back.
    assign s_axis_tready = (state == EMPTY) || ((state == ORIG) && m_axis_tready);
    assign in_xfer       = s_axis_tvalid && s_axis_tready;
    assign out_xfer      = m_axis_tvalid && m_axis_tready;

    generate
        if (DATA_W == DATA_W_DEF) begin : g_pkg_mid
            assign mid_val = mid2(prev, s_axis_tdata);
        end else begin : g_wide_mid
            logic [DATA_W:0] sum;
            assign sum     = {prev[DATA_W-1], prev} + {s_axis_tdata[DATA_W-1], s_axis_tdata};
            assign mid_val = sum[DATA_W:1];
        end
    endgenerate

    always_ff @(posedge s_axis_aclk) begin
        if (rst) begin
            state         <= EMPTY;
            prev          <= '0;
            hold          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        m_axis_tdata  <= mid_val;
                        m_axis_tuser  <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        hold          <= s_axis_tdata;
                        prev          <= s_axis_tdata;
                        state         <= MID;
                    end
                end
                MID: begin
                    if (out_xfer) begin
                        m_axis_tdata <= hold;
                        m_axis_tuser <= 1'b0;
                        state        <= ORIG;
                    end
                end
                ORIG: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            m_axis_tdata <= mid_val;
                            m_axis_tuser <= 1'b1;
                            hold         <= s_axis_tdata;
                            prev         <= s_axis_tdata;
                            state        <= MID;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            state         <= EMPTY;
                        end
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    state         <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp2x_linear.sv
// -----------------------------------------------------------------------------
// tb_interp2x_linear
// Self-checking bench for interp2x_linear. A queue-based reference model
// predicts the output stream from the accepted inputs. A negedge monitor
// compares every output transfer against the model, checks tvalid and stall
// stability, and logs transfers so the directed tests can check literal values.
// -----------------------------------------------------------------------------
module tb_interp2x_linear;

    localparam int W = 16;

    logic                s_axis_aclk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] s_tdata = '0;
    logic                s_tvalid = 1'b0;
    logic                s_tready;
    logic [W-1:0]        m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic                m_tuser;

    interp2x_linear #(.DATA_W(W)) dut (
        .s_axis_aclk  (s_axis_aclk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tuser (m_tuser)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge s_axis_aclk) cyc <= cyc + 1;

    function automatic void chk(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Floor of (a+b)/2 written with plain integer division and a correction
    // for negative odd sums.
    function automatic int fmid(input int a, input int b);
        int s, q;
        s = a + b;
        q = s / 2;
        if (s < 0 && (s % 2) != 0) q = q - 1;
        return q;
    endfunction

    typedef struct { int d; bit u; } exp_t;
    exp_t exp_q[$];
    int   prev_m = 0;

    // Log of observed transfers, used by the directed tests.
    int log_d[$];
    bit log_u[$];
    int log_c[$];
    int in_c[$];

    bit          stalled  = 1'b0;
    logic [W-1:0] stall_d;
    logic         stall_u;

    // Inputs change only at posedge+1. At negedge they hold the values the
    // next rising edge will use.
    always @(negedge s_axis_aclk) begin
        if (rst) begin
            exp_q.delete();
            prev_m  = 0;
            stalled = 1'b0;
        end else begin
            chk("tvalid_vs_model", m_tvalid == (exp_q.size() != 0), int'(m_tvalid), int'(exp_q.size() != 0));
            if (stalled) begin
                chk("stall_tvalid", m_tvalid == 1'b1, int'(m_tvalid), 1);
                chk("stall_tdata", m_tdata == stall_d, int'($signed(m_tdata)), int'($signed(stall_d)));
                chk("stall_tuser", m_tuser == stall_u, int'(m_tuser), int'(stall_u));
            end
            if (m_tvalid && m_tready) begin
                log_d.push_back(int'($signed(m_tdata)));
                log_u.push_back(m_tuser);
                log_c.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1'b0, int'($signed(m_tdata)), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_tdata", int'($signed(m_tdata)) == e.d, int'($signed(m_tdata)), e.d);
                    chk("out_tuser", m_tuser == e.u, int'(m_tuser), int'(e.u));
                end
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back('{d: fmid(prev_m, int'(s_tdata)), u: 1'b1});
                exp_q.push_back('{d: int'(s_tdata), u: 1'b0});
                prev_m = int'(s_tdata);
                in_c.push_back(cyc);
            end
            stalled = m_tvalid && !m_tready;
            stall_d = m_tdata;
            stall_u = m_tuser;
        end
    end

    task automatic do_reset();
        s_tvalid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge s_axis_aclk);
        #1 rst = 1'b0;
    endtask

    // Present x and hold it until accepted. Returns at posedge+1 after the
    // accepting edge.
    task automatic send(input int x);
        int bound;
        bound    = 0;
        s_tdata  = x[W-1:0];
        s_tvalid = 1'b1;
        forever begin
            @(negedge s_axis_aclk);
            if (s_tready) break;
            bound++;
            if (bound > 1000) begin
                chk("send_timeout", 1'b0, bound, 1000);
                break;
            end
        end
        @(posedge s_axis_aclk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int bound;
        bound = 0;
        forever begin
            @(negedge s_axis_aclk);
            if (!m_tvalid) break;
            bound++;
            if (bound > 200) begin
                chk("drain_timeout", 1'b0, bound, 200);
                break;
            end
        end
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic expect_log(input int base, input int idx, input int d, input bit u, input string name);
        if (log_d.size() <= base + idx) begin
            chk(name, 1'b0, log_d.size(), base + idx + 1);
        end else begin
            chk({name, "_data"}, log_d[base+idx] == d, log_d[base+idx], d);
            chk({name, "_user"}, log_u[base+idx] == u, int'(log_u[base+idx]), int'(u));
        end
    endtask

    initial begin
        int base, ibase, sent, acc;

        // Pin the model against hand-computed values.
        chk("model_floor_neg", fmid(-1, 0) == -1, fmid(-1, 0), -1);
        chk("model_mid_max", fmid(32767, 32767) == 32767, fmid(32767, 32767), 32767);

        // Reset state
        do_reset();
        @(negedge s_axis_aclk);
        chk("rst_tready", s_tready == 1'b1, int'(s_tready), 1);
        chk("rst_tvalid", m_tvalid == 1'b0, int'(m_tvalid), 0);
        chk("rst_tdata", m_tdata == '0, int'(m_tdata), 0);
        chk("rst_tuser", m_tuser == 1'b0, int'(m_tuser), 0);
        @(posedge s_axis_aclk);
        #1;

        // 100, 200 back to back with ready high
        base = log_d.size(); ibase = in_c.size();
        m_tready = 1'b1;
        send(100);
        chk("t1_tready_low_in_mid", s_tready == 1'b0, int'(s_tready), 0);
        send(200);
        drain();
        expect_log(base, 0, 50, 1'b1, "t1_o0");
        expect_log(base, 1, 100, 1'b0, "t1_o1");
        expect_log(base, 2, 150, 1'b1, "t1_o2");
        expect_log(base, 3, 200, 1'b0, "t1_o3");
        if (log_c.size() >= base + 4 && in_c.size() > ibase)
            for (int i = 0; i < 4; i++)
                chk("t1_latency", log_c[base+i] == in_c[ibase] + 1 + i, log_c[base+i], in_c[ibase] + 1 + i);
        else
            chk("t1_latency_missing", 1'b0, log_c.size(), base + 4);

        // Floor on negative odd sums
        do_reset();
        base = log_d.size();
        send(-101);
        send(0);
        drain();
        expect_log(base, 0, -51, 1'b1, "t2_o0");
        expect_log(base, 1, -101, 1'b0, "t2_o1");
        expect_log(base, 2, -51, 1'b1, "t2_o2");
        expect_log(base, 3, 0, 1'b0, "t2_o3");

        // Full-scale values must not overflow
        do_reset();
        base = log_d.size();
        send(32767);
        send(32767);
        send(-32768);
        drain();
        expect_log(base, 0, 16383, 1'b1, "t3_m0");
        expect_log(base, 2, 32767, 1'b1, "t3_m1");
        expect_log(base, 4, -1, 1'b1, "t3_m2");
        expect_log(base, 5, -32768, 1'b0, "t3_o2");

        // Backpressure: hold the midpoint for 5 cycles
        do_reset();
        base = log_d.size();
        m_tready = 1'b0;
        send(1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge s_axis_aclk);
            chk("bp_tvalid", m_tvalid == 1'b1, int'(m_tvalid), 1);
            chk("bp_tdata", int'($signed(m_tdata)) == 500, int'($signed(m_tdata)), 500);
            chk("bp_tuser", m_tuser == 1'b1, int'(m_tuser), 1);
            chk("bp_tready", s_tready == 1'b0, int'(s_tready), 0);
        end
        @(posedge s_axis_aclk);
        #1 m_tready = 1'b1;
        drain();
        expect_log(base, 0, 500, 1'b1, "bp_o0");
        expect_log(base, 1, 1000, 1'b0, "bp_o1");

        // Reset while in ORIG
        do_reset();
        send(400);
        @(posedge s_axis_aclk);
        #1 rst = 1'b1;
        @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        chk("rst_mid_tvalid", m_tvalid == 1'b0, int'(m_tvalid), 0);
        @(posedge s_axis_aclk);
        #1 rst = 1'b0;
        base = log_d.size();
        send(400);
        drain();
        expect_log(base, 0, 200, 1'b1, "rr_o0");
        expect_log(base, 1, 400, 1'b0, "rr_o1");
        chk("rr_count", log_d.size() == base + 2, log_d.size() - base, 2);

        // Randomized traffic with random backpressure
        do_reset();
        ibase = in_c.size();
        sent  = 0;
        while (sent < 10000) begin
            if (!s_tvalid || acc != 0) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = W'($urandom());
            end
            m_tready = $urandom_range(0, 1) != 0;
            @(negedge s_axis_aclk);
            acc = (s_tvalid && s_tready) ? 1 : 0;
            sent += acc;
            @(posedge s_axis_aclk);
            #1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        drain();
        chk("rand_inputs", in_c.size() - ibase == 10000, in_c.size() - ibase, 10000);
        chk("rand_leftover", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
